// File: rtl/synth_pkg.sv
// Shared widths and FSM state type for the synth voice datapath blocks.
package synth_pkg;

    localparam int NOTE_W     = 7;
    localparam int PINC_W     = 32;
    localparam int NUM_VOICES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the pointer position has the highest
// priority, then the following indices, wrapping back to 0.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               any
);

    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    // The extra sum bit avoids overflow before the wrap back into range.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/phase_inc_arbiter.sv
// Shares one registered-read phase-increment ROM between several voices,
// round-robin, with a single lookup in flight at a time.
module phase_inc_arbiter
    import synth_pkg::*;
#(
    parameter  int NUM_REQ = NUM_VOICES,
    parameter  int ADDR_W  = NOTE_W,
    parameter  int DATA_W  = PINC_W,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] note_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic                      busy_o,
    output logic [ADDR_W-1:0]         rom_addr_o,
    input  logic [DATA_W-1:0]         rom_data_i
);

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   next_ptr;
    logic               mask_prev;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] win_gnt;
    logic               win_any;
    logic [PTR_W-1:0]   win_idx;
    logic [ADDR_W-1:0]  win_note;

    assign owner_oh = NUM_REQ'(1) << owner;
    assign next_ptr = (owner == PTR_W'(NUM_REQ-1)) ? '0 : owner + PTR_W'(1);

    // Right after a response the owner sits out one IDLE cycle so it can drop its request.
    assign eligible = mask_prev ? (req_i & ~owner_oh) : req_i;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req (eligible),
        .ptr (ptr),
        .gnt (win_gnt),
        .any (win_any)
    );

    always_comb begin
        win_idx  = '0;
        win_note = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_gnt[i]) begin
                win_idx  = PTR_W'(i);
                win_note = note_i[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            mask_prev   <= 1'b0;
            gnt_o       <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            rom_addr_o  <= '0;
        end else begin
            gnt_o       <= '0;
            rsp_valid_o <= '0;
            mask_prev   <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_any && (eligible != '0)) begin
                        rom_addr_o <= win_note;
                        owner      <= win_idx;
                        gnt_o      <= win_gnt;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    state <= WAIT;
                end
                WAIT: begin
                    rsp_data_o  <= rom_data_i;
                    rsp_valid_o <= owner_oh;
                    ptr         <= next_ptr;
                    state       <= RESP;
                end
                RESP: begin
                    mask_prev <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_phase_inc_arbiter.sv
// Scoreboard bench for phase_inc_arbiter: a cycle-count reference model predicts
// grants and responses, a negedge monitor pops and compares them.
module tb_phase_inc_arbiter;
    import synth_pkg::*;

    localparam int N = NUM_VOICES;
    localparam int W = NOTE_W;

    typedef struct {
        int          voice;
        int          edge_no;
        logic [31:0] data;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*W-1:0]  notes;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic            busy;
    logic [W-1:0]    rom_addr;
    logic [31:0]     rom_data;

    int total = 0;
    int bad   = 0;

    exp_t gq[$];
    exp_t rq[$];
    int   cyc        = 0;
    int   ptr_m      = 0;
    int   ready_edge = 0;
    int   last_owner = 0;
    bit   have_prev  = 0;
    int   acc_edge   = -100;
    logic [W-1:0] exp_addr = '0;

    phase_inc_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .note_i      (notes),
        .gnt_o       (gnt),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy),
        .rom_addr_o  (rom_addr),
        .rom_data_i  (rom_data)
    );

    // Bench ROM: entry n holds 0x1000_0000 + n, one-cycle registered read.
    always_ff @(posedge clk) begin
        rom_data <= 32'h1000_0000 + 32'(rom_addr);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one lookup occupies 4 edges, the previous owner sits out the first free edge.
    initial begin
        logic [N-1:0] elig;
        int w;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                gq.delete();
                rq.delete();
                ptr_m = 0; ready_edge = 0; have_prev = 0;
                acc_edge = -100; exp_addr = '0;
            end else begin
                cyc++;
                if (cyc >= ready_edge) begin
                    elig = req;
                    if (have_prev && cyc == ready_edge) elig[last_owner] = 1'b0;
                    if (elig != '0) begin
                        w = -1;
                        for (int k = 0; k < N; k++) begin
                            if (w < 0 && elig[(ptr_m + k) % N]) w = (ptr_m + k) % N;
                        end
                        gq.push_back('{voice: w, edge_no: cyc, data: 32'h0});
                        rq.push_back('{voice: w, edge_no: cyc + 2,
                                       data: 32'h1000_0000 + 32'(notes[w*W +: W])});
                        exp_addr   = notes[w*W +: W];
                        ptr_m      = (w + 1) % N;
                        last_owner = w;
                        have_prev  = 1;
                        ready_edge = cyc + 4;
                        acc_edge   = cyc;
                    end
                end
            end
        end
    end

    // Monitor: compare whatever the DUT presents against the queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (gnt != '0) begin
                if (gq.size() == 0) begin
                    check_output("unexpected_gnt", 64'(gnt), 64'(0));
                end else begin
                    e = gq.pop_front();
                    check_output("gnt_vec", 64'(gnt), 64'(1) << e.voice);
                    check_output("gnt_edge", 64'(cyc), 64'(e.edge_no));
                end
            end else if (gq.size() > 0 && gq[0].edge_no <= cyc) begin
                e = gq.pop_front();
                check_output("missing_gnt", 64'(gnt), 64'(1) << e.voice);
            end
            if (rsp_valid != '0) begin
                if (rq.size() == 0) begin
                    check_output("unexpected_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    e = rq.pop_front();
                    check_output("rsp_vec", 64'(rsp_valid), 64'(1) << e.voice);
                    check_output("rsp_edge", 64'(cyc), 64'(e.edge_no));
                    check_output("rsp_data", 64'(rsp_data), 64'(e.data));
                end
            end else if (rq.size() > 0 && rq[0].edge_no <= cyc) begin
                e = rq.pop_front();
                check_output("missing_rsp", 64'(rsp_valid), 64'(1) << e.voice);
            end
            check_output("busy", 64'(busy), 64'(cyc >= acc_edge && cyc <= acc_edge + 2));
            check_output("rom_addr", 64'(rom_addr), 64'(exp_addr));
        end
    end

    task automatic apply_stimulus(input logic [N-1:0] r, input int v, input int note);
        req = r;
        if (v >= 0) notes[v*W +: W] = W'(note);
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input int v);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (gnt[v]) seen = 1;
        end
        if (!seen) check_output("gnt_timeout", 64'(0), 64'(1) << v);
    endtask

    task automatic wait_idle();
        bit done = 0;
        req = '0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk); #1;
            if (gq.size() == 0 && rq.size() == 0 && !busy) done = 1;
        end
        if (!done) check_output("idle_timeout", 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        notes = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_gnt", 64'(gnt), 64'(0));
        check_output("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check_output("reset_rsp_data", 64'(rsp_data), 64'(0));
        check_output("reset_busy", 64'(busy), 64'(0));
        check_output("reset_rom_addr", 64'(rom_addr), 64'(0));
        #1 rst_n = 1'b1;

        // Single lookup, note 69.
        @(posedge clk); #1;
        apply_stimulus(4'b0001, 0, 69);
        wait_gnt(0);
        req = '0;
        wait_idle();

        // All four voices held continuously.
        apply_reset();
        @(posedge clk); #1;
        apply_stimulus(4'b1111, 0, 10);
        apply_stimulus(4'b1111, 1, 20);
        apply_stimulus(4'b1111, 2, 30);
        apply_stimulus(4'b1111, 3, 40);
        repeat (20) @(posedge clk);
        wait_idle();

        // Voice 2 alone, held through its responses, then everyone: voice 3 goes first.
        apply_reset();
        @(posedge clk); #1;
        apply_stimulus(4'b0100, 2, 33);
        repeat (14) @(posedge clk);
        wait_idle();
        @(posedge clk); #1;
        apply_stimulus(4'b1111, 3, 3);
        wait_gnt(3);
        wait_idle();

        // Voice 1 drops request and changes note in the ADDR cycle.
        @(posedge clk); #1;
        apply_stimulus(4'b0010, 1, 55);
        wait_gnt(1);
        apply_stimulus(4'b0000, 1, 99);
        wait_idle();

        // Reset during WAIT loses the response; voice 3 is served afterwards.
        apply_reset();
        @(posedge clk); #1;
        apply_stimulus(4'b0001, 0, 5);
        wait_gnt(0);
        req = '0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_output("async_gnt", 64'(gnt), 64'(0));
        check_output("async_rsp_valid", 64'(rsp_valid), 64'(0));
        check_output("async_rsp_data", 64'(rsp_data), 64'(0));
        check_output("async_busy", 64'(busy), 64'(0));
        check_output("async_rom_addr", 64'(rom_addr), 64'(0));
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(4'b1000, 3, 77);
        wait_gnt(3);
        wait_idle();

        // Note range boundaries on two voices in the same cycle.
        apply_reset();
        @(posedge clk); #1;
        apply_stimulus(4'b0011, 0, 127);
        apply_stimulus(4'b0011, 1, 0);
        wait_gnt(0);
        req[0] = 1'b0;
        wait_gnt(1);
        wait_idle();

        // Random traffic: requesters hold until granted, then re-request or drop.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int v = 0; v < N; v++) begin
                if (req[v] && gnt[v]) begin
                    req[v] = 1'($urandom_range(0, 1));
                    notes[v*W +: W] = W'($urandom);
                end else if (!req[v] && $urandom_range(0, 3) == 0) begin
                    req[v] = 1'b1;
                    notes[v*W +: W] = W'($urandom);
                end
            end
        end
        wait_idle();

        check_output("gnt_queue_empty", 64'(gq.size()), 64'(0));
        check_output("rsp_queue_empty", 64'(rq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
